// File: rtl/memory_pkg.sv
// Shared definitions for the multi-port memory arbiter: width codes,
// arbitration modes, FSM encoding and load/store data helpers.
package memory_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [3:0] {
    IDLE,
    RD_LO,
    RD_HI,
    RD_CAP,
    WR_LO,
    WR_HI,
    RMW_RD,
    RMW_WR,
    DONE
  } state_t;

  // Both 2'b10 and 2'b11 encode a word access.
  function automatic logic is_word(input logic [1:0] width);
    return width[1];
  endfunction

  function automatic logic [31:0] extend_load(input logic [15:0] data,
                                              input logic [1:0]  width,
                                              input logic        sign_ext,
                                              input logic        hi_byte);
    logic [7:0] b;
    b = hi_byte ? data[15:8] : data[7:0];
    if (width == WIDTH_BYTE) begin
      return sign_ext ? {{24{b[7]}}, b} : {24'h0, b};
    end
    return sign_ext ? {{16{data[15]}}, data} : {16'h0, data};
  endfunction

  function automatic logic [15:0] merge_byte(input logic [15:0] old_data,
                                             input logic [7:0]  new_byte,
                                             input logic        hi_byte);
    return hi_byte ? {new_byte, old_data[7:0]} : {old_data[15:8], new_byte};
  endfunction

endpackage

// File: rtl/memory_port_picker.sv
// Combinational winner selection: fixed priority (lowest index) or
// round-robin starting one past the last winner.
module memory_port_picker
  import memory_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = 1
) (
  input  logic [NUM_PORTS-1:0] i_pending,
  input  logic [PTR_W-1:0]     i_ptr,
  input  logic                 i_mode,
  output logic [NUM_PORTS-1:0] o_winner
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (i_mode == 1'(ARB_RR)) begin
        w_idx = PTR_W'((int'(i_ptr) + 1 + k) % NUM_PORTS);
      end else begin
        w_idx = PTR_W'(k);
      end
      if (!w_found && i_pending[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates NUM_PORTS requesters onto one 16-bit synchronous memory,
// splitting word accesses and doing read-modify-write for byte stores.
module memory_port_arbiter
  import memory_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int ARB_MODE   = 0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_PORTS-1:0]                req_load,
  input  logic [NUM_PORTS-1:0]                req_store,
  input  logic [NUM_PORTS*(ADDR_WIDTH+1)-1:0] req_address,
  input  logic [2*NUM_PORTS-1:0]              req_width,
  input  logic [NUM_PORTS-1:0]                req_signed,
  input  logic [32*NUM_PORTS-1:0]             req_wdata,
  output logic [NUM_PORTS-1:0]                grant,
  output logic [31:0]                         rdata,
  output logic [NUM_PORTS-1:0]                read_valid,
  output logic [NUM_PORTS-1:0]                write_ready,
  output logic                                busy,
  input  logic [15:0]                         from_mem_data,
  output logic                                to_mem_read_enable,
  output logic                                to_mem_write_enable,
  output logic                                to_mem_mem_enable,
  output logic [ADDR_WIDTH-1:0]               to_mem_address,
  output logic [15:0]                         to_mem_data
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BA_W  = ADDR_WIDTH + 1;

  state_t                r_state;
  logic [NUM_PORTS-1:0]  r_grant;
  logic [NUM_PORTS-1:0]  r_read_valid;
  logic [NUM_PORTS-1:0]  r_write_ready;
  logic [31:0]           r_rdata;
  logic [15:0]           r_lo;
  logic [PTR_W-1:0]      r_ptr;
  logic [BA_W-1:0]       r_addr;
  logic [1:0]            r_width;
  logic                  r_signed;
  logic [31:0]           r_wdata;

  logic [NUM_PORTS-1:0]  w_pending;
  logic [NUM_PORTS-1:0]  w_winner;
  logic [PTR_W-1:0]      w_win_idx;
  logic [BA_W-1:0]       w_sel_addr;
  logic [1:0]            w_sel_width;
  logic                  w_sel_signed;
  logic [31:0]           w_sel_wdata;
  logic                  w_sel_load;
  logic [ADDR_WIDTH-1:0] w_a0;
  logic [ADDR_WIDTH-1:0] w_a1;
  logic                  w_rd_en;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [15:0]           w_mem_data;

  // A port asserting both load and store is treated as a load; its store
  // stays pending and wins a later arbitration round.
  assign w_pending = req_load | req_store;

  memory_port_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_picker (
    .i_pending (w_pending),
    .i_ptr     (r_ptr),
    .i_mode    (ARB_MODE == ARB_RR),
    .o_winner  (w_winner)
  );

  always_comb begin
    w_win_idx    = '0;
    w_sel_addr   = '0;
    w_sel_width  = '0;
    w_sel_signed = 1'b0;
    w_sel_wdata  = '0;
    w_sel_load   = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (w_winner[k]) begin
        w_win_idx    = PTR_W'(k);
        w_sel_addr   = req_address[k*BA_W +: BA_W];
        w_sel_width  = req_width[2*k +: 2];
        w_sel_signed = req_signed[k];
        w_sel_wdata  = req_wdata[32*k +: 32];
        w_sel_load   = req_load[k];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_read_valid  <= '0;
      r_write_ready <= '0;
      r_rdata       <= '0;
      r_lo          <= '0;
      r_ptr         <= PTR_W'(NUM_PORTS - 1);
      r_addr        <= '0;
      r_width       <= '0;
      r_signed      <= 1'b0;
      r_wdata       <= '0;
    end else begin
      r_read_valid  <= '0;
      r_write_ready <= '0;
      case (r_state)
        IDLE: begin
          if (|w_pending) begin
            r_grant  <= w_winner;
            r_ptr    <= w_win_idx;
            r_addr   <= w_sel_addr;
            r_width  <= w_sel_width;
            r_signed <= w_sel_signed;
            r_wdata  <= w_sel_wdata;
            if (w_sel_load) begin
              r_state <= RD_LO;
            end else if (w_sel_width == WIDTH_BYTE) begin
              r_state <= RMW_RD;
            end else begin
              r_state <= WR_LO;
            end
          end
        end
        RD_LO: begin
          r_state <= is_word(r_width) ? RD_HI : RD_CAP;
        end
        RD_HI: begin
          r_lo    <= from_mem_data;
          r_state <= RD_CAP;
        end
        RD_CAP: begin
          r_rdata      <= is_word(r_width) ? {from_mem_data, r_lo}
                                           : extend_load(from_mem_data, r_width, r_signed, r_addr[0]);
          r_read_valid <= r_grant;
          r_grant      <= '0;
          r_state      <= DONE;
        end
        WR_LO: begin
          if (is_word(r_width)) begin
            r_state <= WR_HI;
          end else begin
            r_write_ready <= r_grant;
            r_grant       <= '0;
            r_state       <= DONE;
          end
        end
        WR_HI, RMW_WR: begin
          r_write_ready <= r_grant;
          r_grant       <= '0;
          r_state       <= DONE;
        end
        RMW_RD: begin
          r_state <= RMW_WR;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_a0 = r_addr[ADDR_WIDTH:1];
  assign w_a1 = w_a0 + ADDR_WIDTH'(1);

  // Memory strobes decode straight from the state so an async reset drops
  // them immediately; the byte merge uses read data arriving this cycle.
  always_comb begin
    w_rd_en    = 1'b0;
    w_wr_en    = 1'b0;
    w_mem_addr = '0;
    w_mem_data = '0;
    case (r_state)
      RD_LO, RMW_RD: begin
        w_rd_en    = 1'b1;
        w_mem_addr = w_a0;
      end
      RD_HI: begin
        w_rd_en    = 1'b1;
        w_mem_addr = w_a1;
      end
      WR_LO: begin
        w_wr_en    = 1'b1;
        w_mem_addr = w_a0;
        w_mem_data = r_wdata[15:0];
      end
      WR_HI: begin
        w_wr_en    = 1'b1;
        w_mem_addr = w_a1;
        w_mem_data = r_wdata[31:16];
      end
      RMW_WR: begin
        w_wr_en    = 1'b1;
        w_mem_addr = w_a0;
        w_mem_data = merge_byte(from_mem_data, r_wdata[7:0], r_addr[0]);
      end
      default: begin
        w_rd_en = 1'b0;
      end
    endcase
  end

  assign grant               = r_grant;
  assign rdata               = r_rdata;
  assign read_valid          = r_read_valid;
  assign write_ready         = r_write_ready;
  assign busy                = (r_state != IDLE);
  assign to_mem_read_enable  = w_rd_en;
  assign to_mem_write_enable = w_wr_en;
  assign to_mem_mem_enable   = w_rd_en | w_wr_en;
  assign to_mem_address      = w_mem_addr;
  assign to_mem_data         = w_mem_data;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench: a round-robin 3-port arbiter on a modelled synchronous
// memory, plus a fixed-priority twin sharing the request inputs.
module tb_memory_port_arbiter;

  logic        clock;
  logic        resetN;
  logic [2:0]  reqLoad;
  logic [2:0]  reqStore;
  logic [38:0] reqAddress;
  logic [5:0]  reqWidth;
  logic [2:0]  reqSigned;
  logic [95:0] reqWdata;

  logic [2:0]  grant, readValid, writeReady;
  logic [31:0] rdata;
  logic        busy, memRe, memWe, memEn;
  logic [11:0] memAddr;
  logic [15:0] memWdata, memRdata;

  logic [2:0]  grantFix, readValidFix, writeReadyFix;
  logic [31:0] rdataFix;
  logic        busyFix, memReFix, memWeFix, memEnFix;
  logic [11:0] memAddrFix;
  logic [15:0] memWdataFix;
  logic [15:0] fixMemData;

  logic [15:0] mem [4096];
  logic        tbWe;
  logic [11:0] tbAddr;
  logic [15:0] tbData;

  int compareCount;
  int mismatchCount;

  memory_port_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(12), .ARB_MODE(1)) dut (
    .clock(clock), .reset(resetN),
    .req_load(reqLoad), .req_store(reqStore), .req_address(reqAddress),
    .req_width(reqWidth), .req_signed(reqSigned), .req_wdata(reqWdata),
    .grant(grant), .rdata(rdata), .read_valid(readValid), .write_ready(writeReady),
    .busy(busy), .from_mem_data(memRdata),
    .to_mem_read_enable(memRe), .to_mem_write_enable(memWe), .to_mem_mem_enable(memEn),
    .to_mem_address(memAddr), .to_mem_data(memWdata)
  );

  memory_port_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(12), .ARB_MODE(0)) dutFixed (
    .clock(clock), .reset(resetN),
    .req_load(reqLoad), .req_store(reqStore), .req_address(reqAddress),
    .req_width(reqWidth), .req_signed(reqSigned), .req_wdata(reqWdata),
    .grant(grantFix), .rdata(rdataFix), .read_valid(readValidFix), .write_ready(writeReadyFix),
    .busy(busyFix), .from_mem_data(fixMemData),
    .to_mem_read_enable(memReFix), .to_mem_write_enable(memWeFix), .to_mem_mem_enable(memEnFix),
    .to_mem_address(memAddrFix), .to_mem_data(memWdataFix)
  );

  assign fixMemData = 16'h0;

  always #5 clock = ~clock;

  // Read-first synchronous memory; the bench preloads through its own port.
  always @(posedge clock) begin
    if (memWe) mem[memAddr] <= memWdata;
    else if (tbWe) mem[tbAddr] <= tbData;
    if (memRe) memRdata <= mem[memAddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic load, input logic store,
                               input logic [12:0] addr, input logic [1:0] width,
                               input logic sgn, input logic [31:0] wdata);
    reqLoad[port]              = load;
    reqStore[port]             = store;
    reqAddress[port*13 +: 13]  = addr;
    reqWidth[port*2 +: 2]      = width;
    reqSigned[port]            = sgn;
    reqWdata[port*32 +: 32]    = wdata;
  endtask

  task automatic writeMem(input logic [11:0] addr, input logic [15:0] data);
    tbAddr = addr;
    tbData = data;
    tbWe   = 1'b1;
    @(negedge clock);
    tbWe   = 1'b0;
  endtask

  task automatic doLoad(input string tag, input int port, input logic [12:0] addr,
                        input logic [1:0] width, input logic sgn,
                        input logic [31:0] expData, input int doneCycle);
    applyStimulus(port, 1'b1, 1'b0, addr, width, sgn, 32'h0);
    repeat (doneCycle - 1) @(negedge clock);
    checkOutput({tag, " early"}, 32'(readValid), 32'h0);
    @(negedge clock);
    checkOutput({tag, " valid"}, 32'(readValid), 32'(3'b001 << port));
    checkOutput({tag, " data"}, rdata, expData);
    applyStimulus(port, 1'b0, 1'b0, addr, width, sgn, 32'h0);
    @(negedge clock);
  endtask

  task automatic doStore(input string tag, input int port, input logic [12:0] addr,
                         input logic [1:0] width, input logic [31:0] wdata, input int doneCycle);
    applyStimulus(port, 1'b0, 1'b1, addr, width, 1'b0, wdata);
    repeat (doneCycle - 1) @(negedge clock);
    checkOutput({tag, " early"}, 32'(writeReady), 32'h0);
    @(negedge clock);
    checkOutput({tag, " ready"}, 32'(writeReady), 32'(3'b001 << port));
    applyStimulus(port, 1'b0, 1'b0, addr, width, 1'b0, 32'h0);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0] rrExpect [4];
    logic       sawReady;
    rrExpect = '{3'b001, 3'b010, 3'b100, 3'b001};
    compareCount  = 0;
    mismatchCount = 0;
    clock      = 1'b0;
    resetN     = 1'b0;
    reqLoad    = '0;
    reqStore   = '0;
    reqAddress = '0;
    reqWidth   = '0;
    reqSigned  = '0;
    reqWdata   = '0;
    tbWe       = 1'b0;
    tbAddr     = '0;
    tbData     = '0;
    repeat (2) @(negedge clock);

    checkOutput("rst grant", 32'(grant), 32'h0);
    checkOutput("rst busy", 32'(busy), 32'h0);
    checkOutput("rst rdata", rdata, 32'h0);
    checkOutput("rst mem en", 32'({memEn, memRe, memWe}), 32'h0);
    checkOutput("rst mem bus", 32'({memAddr, memWdata}), 32'h0);

    writeMem(12'h008, 16'h1234);
    writeMem(12'h009, 16'hABCD);
    writeMem(12'h001, 16'h80FF);
    writeMem(12'h020, 16'h0000);
    writeMem(12'h021, 16'h7777);
    resetN = 1'b1;
    @(negedge clock);

    $display("[TB] word load on port 1");
    applyStimulus(1, 1'b1, 1'b0, 13'h010, 2'b10, 1'b0, 32'h0);
    @(negedge clock);
    checkOutput("wl grant", 32'(grant), 32'h2);
    checkOutput("wl busy", 32'(busy), 32'h1);
    checkOutput("wl rd lo", 32'({memRe, memWe, memAddr}), {18'h0, 2'b10, 12'h008});
    applyStimulus(1, 1'b1, 1'b0, 13'h100, 2'b00, 1'b1, 32'h0);
    @(negedge clock);
    checkOutput("wl rd hi", 32'({memRe, memWe, memAddr}), {18'h0, 2'b10, 12'h009});
    @(negedge clock);
    checkOutput("wl early", 32'(readValid), 32'h0);
    @(negedge clock);
    checkOutput("wl valid", 32'(readValid), 32'h2);
    checkOutput("wl data", rdata, 32'hABCD1234);
    checkOutput("wl grant off", 32'(grant), 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 13'h0, 2'b00, 1'b0, 32'h0);
    @(negedge clock);
    checkOutput("wl idle", 32'(busy), 32'h0);

    $display("[TB] byte and halfword loads");
    doLoad("sbyte hi", 0, 13'h003, 2'b00, 1'b1, 32'hFFFFFF80, 3);
    doLoad("ubyte hi", 0, 13'h003, 2'b00, 1'b0, 32'h00000080, 3);
    doLoad("ubyte lo", 2, 13'h002, 2'b00, 1'b0, 32'h000000FF, 3);
    doLoad("shalf", 0, 13'h003, 2'b01, 1'b1, 32'hFFFF80FF, 3);

    $display("[TB] stores");
    writeMem(12'h001, 16'h1234);
    doStore("bstore lo", 0, 13'h002, 2'b00, 32'hFFFFFF5A, 3);
    checkOutput("bstore lo mem", 32'(mem[12'h001]), 32'h125A);
    doStore("bstore hi", 1, 13'h003, 2'b00, 32'h000000C3, 3);
    checkOutput("bstore hi mem", 32'(mem[12'h001]), 32'hC35A);
    doStore("hstore", 2, 13'h020, 2'b01, 32'h9999BEAD, 2);
    checkOutput("hstore mem", 32'(mem[12'h010]), 32'hBEAD);
    doStore("wstore wrap", 1, 13'h1FFE, 2'b10, 32'hDEADBEEF, 3);
    checkOutput("wrap lo mem", 32'(mem[12'hFFF]), 32'hBEEF);
    checkOutput("wrap hi mem", 32'(mem[12'h000]), 32'hDEAD);

    $display("[TB] load and store together");
    applyStimulus(0, 1'b1, 1'b1, 13'h010, 2'b01, 1'b0, 32'h00004321);
    @(negedge clock);
    checkOutput("ls first is read", 32'({memRe, memWe}), 32'h2);
    repeat (2) @(negedge clock);
    checkOutput("ls load done", 32'({readValid, writeReady}), 32'h08);
    checkOutput("ls load data", rdata, 32'h00001234);
    reqLoad[0] = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("ls store write", 32'({memWe, memAddr, memWdata}), {3'b0, 1'b1, 12'h008, 16'h4321});
    @(negedge clock);
    checkOutput("ls store ready", 32'(writeReady), 32'h1);
    reqStore[0] = 1'b0;
    @(negedge clock);
    checkOutput("ls mem", 32'(mem[12'h008]), 32'h4321);

    $display("[TB] arbitration, all ports loading");
    resetN = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    for (int p = 0; p < 3; p++) applyStimulus(p, 1'b1, 1'b0, 13'h010, 2'b01, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput($sformatf("rr grant %0d", i), 32'(grant), 32'(rrExpect[i]));
      checkOutput($sformatf("fixed grant %0d", i), 32'(grantFix), 32'h1);
      repeat (3) @(negedge clock);
    end
    for (int p = 0; p < 3; p++) applyStimulus(p, 1'b0, 1'b0, 13'h0, 2'b00, 1'b0, 32'h0);
    repeat (4) @(negedge clock);

    $display("[TB] reset during the high half of a word store");
    applyStimulus(0, 1'b0, 1'b1, 13'h040, 2'b10, 1'b0, 32'h12345678);
    repeat (2) @(negedge clock);
    checkOutput("rst wr hi", 32'({memWe, memAddr}), {19'h0, 1'b1, 12'h021});
    #1 resetN = 1'b0;
    #1;
    checkOutput("rst abort en", 32'({memEn, memRe, memWe}), 32'h0);
    checkOutput("rst abort busy", 32'({busy, grant}), 32'h0);
    applyStimulus(0, 1'b0, 1'b0, 13'h0, 2'b00, 1'b0, 32'h0);
    @(negedge clock);
    resetN = 1'b1;
    sawReady = 1'b0;
    repeat (3) begin
      @(negedge clock);
      sawReady = sawReady | (|writeReady);
    end
    checkOutput("rst no ready", 32'(sawReady), 32'h0);
    checkOutput("rst idle", 32'(busy), 32'h0);
    checkOutput("rst lo kept", 32'(mem[12'h020]), 32'h5678);
    checkOutput("rst hi untouched", 32'(mem[12'h021]), 32'h7777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
